seqdect_ctrl: RTL

SEQDECT_CTRL -- requirements
Module: seqdect_ctrl

---
 rtl/seqdect_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seqdect_ctrl.sv
// Serial pattern detector: hunts for a configurable 1..8 bit pattern on prtx.
// It pulses prtz one cycle after each match and can stop after cfg_max matches.
module seqdect_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [7:0] cfg_pattern,
    input  logic [3:0] cfg_len,
    input  logic       cfg_overlap,
    input  logic [7:0] cfg_max,
    input  logic       start,
    input  logic       abort,
    input  logic       prtx,
    output logic       prtz,
    output logic       busy,
    output logic       done,
    output logic [7:0] match_cnt
);

    typedef enum logic [1:0] {StIdle, StHunt, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] pat_q;
    logic [3:0] len_q;
    logic       ovl_q;
    logic [7:0] max_q;
    logic [7:0] win_q;
    logic [3:0] cnt_q;
    logic [7:0] mcnt_q;
    logic       prtz_q;

    logic [7:0] win_shift;
    logic [7:0] len_mask;
    logic       cnt_full;
    logic       hit;
    logic       match;
    logic [7:0] mcnt_inc;
    logic       reach_max;
    logic [3:0] len_clip;

    always_comb begin
        win_shift = {win_q[6:0], prtx};
        // len_q is always 1..8, so the shift amount stays within 0..7.
        len_mask  = 8'hFF >> (4'd8 - len_q);
        cnt_full  = ({1'b0, cnt_q} + 5'd1) >= {1'b0, len_q};
        hit       = (state_q == StHunt) && cnt_full &&
                    ((win_shift & len_mask) == (pat_q & len_mask));
        match     = hit && !abort;
        mcnt_inc  = (mcnt_q == 8'hFF) ? mcnt_q : mcnt_q + 8'd1;
        reach_max = match && (max_q != 8'd0) && (mcnt_inc == max_q);
        if (cfg_len == 4'd0) begin
            len_clip = 4'd1;
        end else if (cfg_len > 4'd8) begin
            len_clip = 4'd8;
        end else begin
            len_clip = cfg_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StHunt;
                end
            end
            StHunt: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (reach_max) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= 8'h0A;
            len_q  <= 4'd4;
            ovl_q  <= 1'b1;
            max_q  <= 8'd0;
            win_q  <= 8'd0;
            cnt_q  <= 4'd0;
            mcnt_q <= 8'd0;
            prtz_q <= 1'b0;
        end else begin
            prtz_q <= match;
            if (state_q != StHunt) begin
                if (cfg_we) begin
                    pat_q <= cfg_pattern;
                    len_q <= len_clip;
                    ovl_q <= cfg_overlap;
                    max_q <= cfg_max;
                end
                if (start && !abort) begin
                    win_q  <= 8'd0;
                    cnt_q  <= 4'd0;
                    mcnt_q <= 8'd0;
                end
            end else if (!abort) begin
                win_q <= win_shift;
                if (match && !ovl_q) begin
                    cnt_q <= 4'd0;
                end else if (cnt_q < len_q) begin
                    cnt_q <= cnt_q + 4'd1;
                end
                if (match) begin
                    mcnt_q <= mcnt_inc;
                end
            end
        end
    end

    always_comb begin
        prtz      = prtz_q;
        busy      = (state_q == StHunt);
        done      = (state_q == StDone);
        match_cnt = mcnt_q;
    end

endmodule
